// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers on the MEM-stage bus, serialiser,
// oversampling-free mid-bit deserialiser and a registered level interrupt.
module uart_mmio #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irq
);
    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]     RXD_ADDR = BASE_ADDR + 32'd4;
    localparam logic [31:0]     CON_ADDR = BASE_ADDR + 32'd8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic             sel_txd, sel_rxd, sel_con;
    logic             wr_txd, wr_con, rd_rxd, rd_con;
    logic [1:0]       tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_data, tx_data_n;
    logic             tx_line_n, tx_fin, tx_busy;
    logic             tx_done, tx_done_n;
    logic             tx_ie, tx_ie_n, rx_ie, rx_ie_n;
    logic             rx_s1, rx_s2, rx_prev;
    logic [1:0]       rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n, rx_data, rx_data_n;
    logic             rx_load;
    logic             rx_ready, rx_ready_n, rx_overrun, rx_overrun_n;
    logic             irq_n;
    logic             unused_wdata;

    assign sel_txd      = (Addr == BASE_ADDR);
    assign sel_rxd      = (Addr == RXD_ADDR);
    assign sel_con      = (Addr == CON_ADDR);
    assign wr_txd       = MemWr & sel_txd;
    assign wr_con       = MemWr & sel_con;
    assign rd_rxd       = MemRd & sel_rxd;
    assign rd_con       = MemRd & sel_con;
    assign tx_busy      = (tx_state != S_IDLE);
    assign unused_wdata = ^WriteData[31:8];

    // State and datapath registers; the RX synchroniser resets to the idle level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state   <= S_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_data    <= '0;
            UART_TX    <= 1'b1;
            tx_done    <= 1'b0;
            tx_ie      <= 1'b0;
            rx_ie      <= 1'b0;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_data    <= '0;
            rx_ready   <= 1'b0;
            rx_overrun <= 1'b0;
            irq        <= 1'b0;
        end else begin
            tx_state   <= tx_state_n;
            tx_cnt     <= tx_cnt_n;
            tx_bit     <= tx_bit_n;
            tx_data    <= tx_data_n;
            UART_TX    <= tx_line_n;
            tx_done    <= tx_done_n;
            tx_ie      <= tx_ie_n;
            rx_ie      <= rx_ie_n;
            rx_s1      <= UART_RX;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_shift   <= rx_shift_n;
            rx_data    <= rx_data_n;
            rx_ready   <= rx_ready_n;
            rx_overrun <= rx_overrun_n;
            irq        <= irq_n;
        end
    end

    // TX: a TXD write is only accepted from IDLE, so writes during a frame drop out
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_data_n  = tx_data;
        tx_line_n  = UART_TX;
        tx_fin     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                if (wr_txd) begin
                    tx_data_n  = WriteData[7:0];
                    tx_state_n = S_START;
                    tx_cnt_n   = '0;
                    tx_line_n  = 1'b0;
                end
            end
            default: begin
                if (tx_cnt != BIT_END) begin
                    tx_cnt_n = tx_cnt + CNT_W'(1);
                end else begin
                    tx_cnt_n = '0;
                    if (tx_state == S_START) begin
                        tx_state_n = S_DATA;
                        tx_bit_n   = '0;
                        tx_line_n  = tx_data[0];
                    end else if (tx_state == S_DATA && tx_bit != 3'd7) begin
                        tx_bit_n  = tx_bit + 3'd1;
                        tx_line_n = tx_data[tx_bit + 3'd1];
                    end else if (tx_state == S_DATA) begin
                        tx_state_n = S_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_state_n = S_IDLE;
                        tx_fin     = 1'b1;
                    end
                end
            end
        endcase
    end

    // RX: half-bit wait re-qualifies the start bit, then one sample per bit period
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_load    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    rx_state_n = S_START;
                    rx_cnt_n   = '0;
                end
            end
            S_START: begin
                if (rx_cnt != HALF_END) begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end else begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_cnt != BIT_END) begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end else begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = S_STOP;
                end
            end
            default: begin
                if (rx_cnt != BIT_END) begin
                    rx_cnt_n = rx_cnt + CNT_W'(1);
                end else begin
                    rx_cnt_n   = '0;
                    rx_state_n = S_IDLE;
                    rx_load    = rx_s2;
                end
            end
        endcase
    end

    // Status flags: a set on the same edge as its read-clear wins
    always_comb begin
        tx_done_n    = tx_fin | (tx_done & ~rd_con);
        rx_ready_n   = rx_load | (rx_ready & ~rd_rxd);
        rx_overrun_n = (rx_load & rx_ready) | (rx_overrun & ~rd_con);
        rx_data_n    = rx_load ? rx_shift : rx_data;
        tx_ie_n      = wr_con ? WriteData[0] : tx_ie;
        rx_ie_n      = wr_con ? WriteData[1] : rx_ie;
        irq_n        = (tx_ie & tx_done) | (rx_ie & rx_ready);
    end

    always_comb begin
        ReadData = '0;
        if (MemRd) begin
            if (sel_txd) begin
                ReadData = {24'd0, tx_data};
            end else if (sel_rxd) begin
                ReadData = {24'd0, rx_data};
            end else if (sel_con) begin
                ReadData = {26'd0, rx_overrun, tx_busy, rx_ready, tx_done, rx_ie, tx_ie};
            end
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: a timeline model of frames and flags checked every cycle,
// directed scenarios with literal expectations, and a randomized concurrent phase.
module tb_uart_mmio;
    localparam int          C     = 8;
    localparam logic [31:0] BASE  = 32'h4000_0018;
    localparam logic [31:0] TXD_A = BASE;
    localparam logic [31:0] RXD_A = BASE + 32'd4;
    localparam logic [31:0] CON_A = BASE + 32'd8;

    logic        clk, reset, MemRd, MemWr, UART_RX, UART_TX, irq;
    logic [31:0] Addr, WriteData, ReadData;

    int n_cmp = 0;
    int n_err = 0;

    // Model: frames as (start edge, byte), RX completions as a due-edge queue
    int         cyc      = 0;
    bit         m_active = 0;
    int         m_start  = 0;
    logic [7:0] m_byte   = 8'd0;
    bit         m_done = 0, m_tx_ie = 0, m_rx_ie = 0, m_ready = 0, m_ov = 0;
    logic [7:0] m_rxd  = 8'd0;
    bit         m_irq  = 0;
    bit         m_line = 1;
    int         due_q[$];
    logic [7:0] byte_q[$];

    uart_mmio #(.CLKS_PER_BIT(C), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
        .WriteData(WriteData), .ReadData(ReadData), .UART_RX(UART_RX),
        .UART_TX(UART_TX), .irq(irq)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit rd_con, rd_rxd, wr_txd, wr_con, fin, load;
        logic [7:0] lb;
        int off;
        if (!reset) begin
            cyc = 0; m_active = 0; m_start = 0; m_byte = 0; m_done = 0; m_tx_ie = 0;
            m_rx_ie = 0; m_ready = 0; m_ov = 0; m_rxd = 0; m_irq = 0; m_line = 1;
            due_q.delete(); byte_q.delete();
            return;
        end
        cyc++;
        rd_con = MemRd && (Addr == CON_A);
        rd_rxd = MemRd && (Addr == RXD_A);
        wr_txd = MemWr && (Addr == TXD_A);
        wr_con = MemWr && (Addr == CON_A);
        fin    = m_active && (cyc - m_start == 10 * C);
        load   = 0;
        lb     = 8'd0;
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            if (due_q[0] == cyc) begin
                load = 1;
                lb   = byte_q[0];
            end
            void'(due_q.pop_front());
            void'(byte_q.pop_front());
        end
        m_irq   = (m_tx_ie & m_done) | (m_rx_ie & m_ready);
        m_ov    = (load & m_ready) | (m_ov & ~rd_con);
        m_ready = load | (m_ready & ~rd_rxd);
        if (load) m_rxd = lb;
        m_done  = fin | (m_done & ~rd_con);
        if (wr_con) begin
            m_tx_ie = WriteData[0];
            m_rx_ie = WriteData[1];
        end
        if (fin) m_active = 0;
        else if (wr_txd && !m_active) begin
            m_active = 1;
            m_start  = cyc;
            m_byte   = WriteData[7:0];
        end
        if (m_active) begin
            off = (cyc - m_start) / C;
            if (off == 0)      m_line = 0;
            else if (off == 9) m_line = 1;
            else               m_line = m_byte[3'(off - 1)];
        end else begin
            m_line = 1;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == TXD_A) return {24'd0, m_byte};
        if (a == RXD_A) return {24'd0, m_rxd};
        if (a == CON_A) return {26'd0, m_ov, m_active, m_ready, m_done, m_rx_ie, m_tx_ie};
        return 32'd0;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    // Registered outputs checked against the model on every falling edge
    initial forever begin
        @(negedge clk);
        if (reset) begin
            chk("uart_tx", 32'(UART_TX), 32'(m_line));
            chk("irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWr = 1; Addr = a; WriteData = d;
        @(negedge clk);
        MemWr = 0; Addr = 0; WriteData = 0;
    endtask

    task automatic bus_read(input string name, input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        MemRd = 1; Addr = a;
        #1;
        d = ReadData;
        chk(name, d, model_read(a));
        @(negedge clk);
        MemRd = 0; Addr = 0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        UART_RX = 0;
        if (stop_ok) begin
            due_q.push_back(cyc + 1 + 2 + C / 2 + 9 * C);
            byte_q.push_back(b);
        end
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (C) @(negedge clk);
        end
        UART_RX = stop_ok;
        repeat (C) @(negedge clk);
        UART_RX = 1;
        repeat (2 * C) @(negedge clk);
    endtask

    task automatic rx_glitch();
        @(negedge clk);
        UART_RX = 0;
        repeat (3) @(negedge clk);
        UART_RX = 1;
        repeat (3 * C) @(negedge clk);
    endtask

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        logic [31:0] d;
        logic [9:0]  sampled;
        reset = 0; MemRd = 0; MemWr = 0; Addr = 0; WriteData = 0; UART_RX = 1;
        repeat (3) @(negedge clk);
        MemRd = 1; Addr = CON_A;
        #1;
        chk("reset_con", ReadData, 32'h0);
        chk("reset_tx", 32'(UART_TX), 32'h1);
        chk("reset_irq", 32'(irq), 32'h0);
        MemRd = 0; Addr = 0;
        @(negedge clk);
        reset = 1;

        // TX frame of 0x55 with tx interrupt enabled
        bus_write(CON_A, 32'h1);
        bus_write(TXD_A, 32'h55);
        sampled = '0;
        repeat (C / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            sampled[i] = UART_TX;
            if (i < 9) repeat (C) @(negedge clk);
        end
        chk("t1_frame_bits", 32'(sampled), 32'h2AA);
        bus_read("t1_con_busy", CON_A, d); chk("t1_con_busy_lit", d, 32'h11);
        repeat (10) @(negedge clk);
        chk("t1_irq_hi", 32'(irq), 32'h1);
        bus_read("t1_con_done", CON_A, d); chk("t1_con_done_lit", d, 32'h05);
        bus_read("t1_con_clr", CON_A, d); chk("t1_con_clr_lit", d, 32'h01);
        repeat (2) @(negedge clk);
        chk("t1_irq_lo", 32'(irq), 32'h0);
        bus_write(CON_A, 32'h0);

        // Single RX frame
        rx_frame(8'hA3, 1);
        bus_read("t2_con", CON_A, d); chk("t2_con_lit", d, 32'h08);
        bus_read("t2_rxd", RXD_A, d); chk("t2_rxd_lit", d, 32'hA3);
        bus_read("t2_con_clr", CON_A, d); chk("t2_con_clr_lit", d, 32'h00);

        // Overrun
        rx_frame(8'h11, 1);
        rx_frame(8'h22, 1);
        bus_read("t3_con_ov", CON_A, d); chk("t3_con_ov_lit", d, 32'h28);
        bus_read("t3_con_ov2", CON_A, d); chk("t3_con_ov2_lit", d, 32'h08);
        bus_read("t3_rxd", RXD_A, d); chk("t3_rxd_lit", d, 32'h22);
        bus_read("t3_con_end", CON_A, d); chk("t3_con_end_lit", d, 32'h00);

        // Glitch and framing error, then a clean frame
        rx_glitch();
        bus_read("t4_glitch_con", CON_A, d); chk("t4_glitch_con_lit", d, 32'h00);
        rx_frame(8'h5A, 0);
        bus_read("t4_ferr_con", CON_A, d); chk("t4_ferr_con_lit", d, 32'h00);
        bus_read("t4_ferr_rxd", RXD_A, d); chk("t4_ferr_rxd_lit", d, 32'h22);
        rx_frame(8'h3C, 1);
        bus_read("t4_ok_rxd", RXD_A, d); chk("t4_ok_rxd_lit", d, 32'h3C);

        // RX interrupt
        bus_write(CON_A, 32'h2);
        rx_frame(8'h96, 1);
        chk("rx_irq_hi", 32'(irq), 32'h1);
        bus_read("rx_irq_rxd", RXD_A, d); chk("rx_irq_rxd_lit", d, 32'h96);
        repeat (2) @(negedge clk);
        chk("rx_irq_lo", 32'(irq), 32'h0);
        bus_write(CON_A, 32'h0);

        // Write while busy is dropped, including on the completion edge
        bus_write(TXD_A, 32'h0F);
        repeat (8) @(negedge clk);
        bus_write(TXD_A, 32'hF0);
        bus_read("t5_txd", TXD_A, d); chk("t5_txd_lit", d, 32'h0F);
        repeat (80) @(negedge clk);
        bus_read("t5_con", CON_A, d); chk("t5_con_lit", d, 32'h04);
        bus_read("t5_con2", CON_A, d); chk("t5_con2_lit", d, 32'h00);
        bus_write(TXD_A, 32'h3C);
        repeat (78) @(negedge clk);
        bus_write(TXD_A, 32'hAA);
        bus_read("t5_edge_txd", TXD_A, d); chk("t5_edge_txd_lit", d, 32'h3C);
        bus_read("t5_edge_con", CON_A, d); chk("t5_edge_con_lit", d, 32'h04);

        // Simultaneous read and write, decode misses, read strobe low
        bus_write(CON_A, 32'h1);
        @(negedge clk);
        MemRd = 1; MemWr = 1; Addr = CON_A; WriteData = 32'hFFFF_FFF2;
        #1;
        chk("rdwr_old", ReadData, 32'h01);
        @(negedge clk);
        MemRd = 0; MemWr = 0; Addr = 0; WriteData = 0;
        bus_read("rdwr_new", CON_A, d); chk("rdwr_new_lit", d, 32'h02);
        bus_read("miss_p1", BASE + 32'd1, d); chk("miss_p1_lit", d, 32'h0);
        bus_read("miss_p12", BASE + 32'd12, d); chk("miss_p12_lit", d, 32'h0);
        @(negedge clk);
        Addr = CON_A;
        #1;
        chk("rd_low", ReadData, 32'h0);
        Addr = 0;
        bus_write(CON_A, 32'h0);

        // Reset mid-frame
        bus_write(TXD_A, 32'hC3);
        repeat (30) @(negedge clk);
        #2 reset = 0;
        #1;
        chk("t6_tx_async", 32'(UART_TX), 32'h1);
        MemRd = 1; Addr = CON_A;
        #1;
        chk("t6_con_zero", ReadData, 32'h0);
        MemRd = 0; Addr = 0;
        @(negedge clk);
        reset = 1;
        bus_write(TXD_A, 32'h5B);
        repeat (85) @(negedge clk);
        bus_read("t6_con_done", CON_A, d); chk("t6_con_done_lit", d, 32'h04);
        bus_read("t6_txd", TXD_A, d); chk("t6_txd_lit", d, 32'h5B);

        // Randomized concurrent bus traffic and RX frames
        bus_write(CON_A, 32'h3);
        fork
            begin
                for (int k = 0; k < 5; k++)
                    rx_frame(8'($urandom), $urandom_range(0, 3) != 0);
            end
            begin
                for (int k = 0; k < 50; k++) begin
                    case ($urandom_range(0, 3))
                        0:       bus_write(TXD_A, $urandom);
                        1:       bus_write(CON_A, 32'($urandom_range(0, 3)));
                        2:       bus_read("rnd_con", CON_A, d);
                        default: repeat ($urandom_range(1, 20)) @(negedge clk);
                    endcase
                end
            end
        join
        repeat (100) @(negedge clk);
        bus_read("rnd_rxd", RXD_A, d);
        bus_read("rnd_con_end", CON_A, d);
        bus_read("rnd_txd", TXD_A, d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
